pe_array_gen: RTL and testbench

PE_ARRAY_GEN -- requirements
Module: pe_array_gen

---
 rtl/pe_array_gen.sv | 113 +++++++++++
 tb/tb_pe_array_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pe_array_gen.sv
// pe_array_gen: KxK sliding-window MAC array; each accepted input slice yields COLS signed
// column results once K samples of the row have been seen, with double-buffered weights.
module pe_array_gen #(
  parameter int COLS = 4,
  parameter int K = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sol,
  input  logic [COLS+K-2:0][DATA_W-1:0] inputs_mac,
  input  logic                          w_wr,
  input  logic [$clog2(K*K)-1:0]        w_addr,
  input  logic [DATA_W-1:0]             w_data,
  input  logic                          w_swap,
  output logic                          out_valid,
  output logic                          out_sol,
  output logic [COLS-1:0][ACC_W-1:0]    outputs_mac,
  output logic                          busy
);
  localparam int N = K * K;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [CW-1:0] FULL = CW'(K);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2;

  if (K < 2 || K > 7 || ACC_W < 2 * DATA_W + $clog2(N)) begin : g_param_check
    $error("pe_array_gen: K must be 2..7 and ACC_W >= 2*DATA_W + clog2(K*K)");
  end

  logic [1:0] state;
  logic [CW-1:0] cnt, idx;
  logic acc, qual, v1, s1, v2, s2;
  logic signed [DATA_W-1:0] shadow [N];
  logic signed [DATA_W-1:0] active [N];
  logic [K-2:0][COLS+K-2:0][DATA_W-1:0] taps;
  logic [K-1:0][COLS+K-2:0][DATA_W-1:0] win;
  logic [ACC_W-1:0] rs_d [COLS][K];
  logic [ACC_W-1:0] rs_q [COLS][K];
  logic [COLS-1:0][ACC_W-1:0] sum_d, sum_q;

  // cnt saturates at K so that only the n=K-1 result carries out_sol
  assign acc = in_valid && (state != IDLE || in_sol);
  assign idx = in_sol ? '0 : cnt;
  assign qual = acc && idx >= LAST;
  assign win = {inputs_mac, taps};
  assign busy = state != IDLE || v1 || v2;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      taps <= '0;
    end else if (acc) begin
      state <= in_sol ? FILL : idx == LAST ? RUN : state;
      cnt <= idx == FULL ? FULL : idx + CW'(1);
      taps <= win[K-1:1];
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_wr && w_addr == AW'(i)) shadow[i] <= w_data;
        if (w_swap) active[i] <= (w_wr && w_addr == AW'(i)) ? w_data : shadow[i];
      end
    end

  // products use the weights active at acceptance, so a same-edge swap does not affect this sample
  always_comb begin
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < K; r++) begin
        rs_d[c][r] = '0;
        for (int j = 0; j < K; j++)
          rs_d[c][r] += ACC_W'(active[r*K+j]) * ACC_W'($signed(win[j][c+r]));
      end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < K; r++)
        sum_d[c] = sum_d[c] + rs_q[c][r];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      v2 <= 1'b0;
      s2 <= 1'b0;
      out_valid <= 1'b0;
      out_sol <= 1'b0;
      rs_q <= '{default: '0};
      sum_q <= '0;
      outputs_mac <= '0;
    end else begin
      v1 <= qual;
      s1 <= qual && idx == LAST;
      if (qual) rs_q <= rs_d;
      v2 <= v1;
      s2 <= s1;
      if (v1) sum_q <= sum_d;
      out_valid <= v2;
      out_sol <= s2;
      if (v2) outputs_mac <= sum_q;
    end
endmodule

// File: tb/tb_pe_array_gen.sv
// tb_pe_array_gen: directed stimulus with a queue of hand-computed results checked by a monitor.
module tb_pe_array_gen;
  logic clk = 0, rst = 1, in_valid = 0, in_sol = 0, w_wr = 0, w_swap = 0;
  logic [5:0][7:0] inputs_mac = '0;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic out_valid, out_sol, busy;
  logic [3:0][31:0] outputs_mac;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct packed {
    logic sol;
    logic [3:0][31:0] e;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t mt;

  pe_array_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sol(in_sol), .inputs_mac(inputs_mac),
    .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data), .w_swap(w_swap),
    .out_valid(out_valid), .out_sol(out_sol), .outputs_mac(outputs_mac), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every out_valid must match the oldest outstanding expectation, 3 cycles after issue
  always @(negedge clk)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", longint'(out_valid), 0);
      else begin
        mt = q.pop_front();
        for (int c = 0; c < 4; c++)
          chk($sformatf("outputs_mac[%0d]", c), $signed(outputs_mac[c]), $signed(mt.e[c]));
        chk("out_sol", longint'(out_sol), longint'(mt.sol));
        chk("latency", cyc - mt.cyc, 3);
      end
    end

  task automatic drive(input bit v, input bit sol, input int a, input int b,
                       input bit ww = 0, input int wa = 0, input int wd = 0, input bit sw = 0);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sol = sol;
    for (int i = 0; i < 6; i++) inputs_mac[i] = 8'(a + b * i);
    w_wr = ww;
    w_addr = 4'(wa);
    w_data = 8'(wd);
    w_swap = sw;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic load(input int w0, input int rest);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 1, i, i == 0 ? w0 : rest);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic push(input bit sol, input int e0, input int e1, input int e2, input int e3);
    exp_t t;
    t.sol = sol;
    t.e[0] = 32'(e0);
    t.e[1] = 32'(e1);
    t.e[2] = 32'(e2);
    t.e[3] = 32'(e3);
    t.cyc = cyc;
    q.push_back(t);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sol", longint'(out_sol), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_outputs_zero", longint'(outputs_mac == '0), 1);
    rst = 0;
    // all-ones weights, x[i]=i+1 constant: 3*(3c+6)
    load(1, 1);
    for (int n = 0; n < 5; n++) begin
      drive(1, n == 0, 1, 1);
      if (n >= 2) push(n == 2, 18, 27, 36, 45);
    end
    idle(1);
    drain();
    // W[0]=1 only, x[i]=n*(i+1): output is the oldest tap (n-2)*(c+1)
    load(1, 0);
    for (int n = 0; n < 5; n++) begin
      drive(1, n == 0, n, n);
      if (n >= 2) push(n == 2, n - 2, 2 * (n - 2), 3 * (n - 2), 4 * (n - 2));
    end
    idle(1);
    drain();
    // same row with 1..3 idle cycles between samples
    for (int n = 0; n < 5; n++) begin
      drive(1, n == 0, n, n);
      if (n >= 2) push(n == 2, n - 2, 2 * (n - 2), 3 * (n - 2), 4 * (n - 2));
      idle(1 + n % 3);
    end
    drain();
    idle(3);
    for (int c = 0; c < 4; c++)
      chk($sformatf("hold_outputs[%0d]", c), $signed(outputs_mac[c]), 2 * (c + 1));
    // swap with W[4]=-128 on sample n=2; out-of-range address 9 must not land anywhere
    drive(1, 1, 0, 1);
    drive(1, 0, 1, 1, 1, 9, 7);
    drive(1, 0, 2, 1, 1, 4, -128, 1);
    push(1, 0, 1, 2, 3);
    drive(1, 0, 3, 1);
    push(0, -383, -510, -637, -764);
    idle(1);
    drain();
    // extremes: every x and W is -128
    load(-128, -128);
    for (int n = 0; n < 4; n++) begin
      drive(1, n == 0, -128, 0);
      if (n >= 2) push(n == 2, 147456, 147456, 147456, 147456);
    end
    idle(1);
    drain();
    // reset one cycle after n=3: in-flight n=2/3 results must vanish
    for (int n = 0; n < 4; n++) drive(1, n == 0, 1, 0);
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    in_sol = 0;
    @(posedge clk);
    #1;
    rst = 0;
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_outputs_zero", longint'(outputs_mac == '0), 1);
    drive(1, 0, 1, 0);
    idle(5);
    chk("idle_ignores_no_sol_busy", longint'(busy), 0);
    chk("idle_outputs_zero", longint'(outputs_mac == '0), 1);
    load(1, 1);
    for (int n = 0; n < 3; n++) drive(1, n == 0, 0, 1);
    push(1, 9, 18, 27, 36);
    idle(1);
    drain();
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
